bmu_issue_arbiter: RTL and testbench
====================================

Name: bmu_issue_arbiter

Overview:
- Shares one BMU between NUM_REQ requesters (e.g. two issue lanes or a lane plus a CSR/debug port).
- Arbitrates round-robin, drives the BMU operand/control inputs for one cycle, and captures the BMU's registered result and error on the following cycle.
- Returns each result with the requester ID over a valid/ready response channel.
- Sits between the issue logic and the BMU instance; one operation is in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OP_W, 23, width of the packed BMU control vector, passed through unmodified.
- ID_W, 3, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: drops the in-flight op and any pending response.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  operand A per requester; slice i = bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B per requester.
- req_op  in  NUM_REQ*OP_W  packed control vector per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  32  captured BMU result.
- rsp_error  out  1  captured BMU error.
- bmu_valid_in  out  1  drives BMU valid_in.
- bmu_a_in  out  32  drives BMU a_in.
- bmu_b_in  out  32  drives BMU b_in.
- bmu_ap  out  OP_W  drives the BMU control struct.
- bmu_result_ff  in  32  BMU result_ff.
- bmu_error  in  1  BMU error.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_error=0, req_ready=0, bmu_valid_in=0, busy=0.
- BMU operand and control outputs are 0 whenever bmu_valid_in=0.

FSM states IDLE, WAIT and RESP:
- IDLE:
  - Grant g is the first requester with req_valid=1, searching from rr_ptr+1 upward with wrap-around.
  - In the grant cycle, combinationally: req_ready[g]=1, bmu_valid_in=1, and bmu_a_in/bmu_b_in/bmu_ap = slice g.
  - At the clock edge: rr_ptr<=g, id_q<=g, state->WAIT.
  - If no req_valid is high, stay in IDLE.
- WAIT:
  - bmu_valid_in=0; bmu_result_ff/bmu_error now hold the op's result (BMU latency is 1 register).
  - At the clock edge: rsp_data<=bmu_result_ff, rsp_error<=bmu_error, rsp_id<=id_q, rsp_valid<=1, state->RESP.
- RESP:
  - rsp_valid holds, and rsp_data/rsp_error/rsp_id stay stable, until rsp_ready=1.
  - On rsp_ready=1, rsp_valid<=0 at the edge.
  - In the same cycle the arbiter may grant a new request exactly as in IDLE (back-to-back) and go to WAIT; otherwise it goes to IDLE.
- Throughput: 1 op per 2 cycles at best; issue-to-rsp_valid latency is 2 cycles.
- Requesters must hold req_valid and the operands stable until req_ready; a request withdrawn before req_ready is never issued.
- Fairness: a requester held continuously valid is granted within NUM_REQ grants.
- flush:
  - Highest priority; flush in any state forces state->IDLE and rsp_valid<=0 at the next edge.
  - No grant occurs in a flush cycle: req_ready=0 and bmu_valid_in=0.
  - rr_ptr is unchanged.
- Asynchronous reset mid-operation: all state returns to the reset values immediately; the in-flight result is discarded.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro: BMU_ARB_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt[15:0], reset to 0.
  - Increments at each rsp handshake (rsp_valid&&rsp_ready) with rsp_error=1.
  - Saturates at 16'hFFFF; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req0 valid with a=5, b=7, op=add → bmu_valid_in pulses 1 cycle with a=5, b=7; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_error=0.
- Contention: req0 and req1 both valid continuously after reset → grant order 0,1,0,1; responses alternate rsp_id 0,1,0,1; a new grant every 2 cycles with rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stay stable, no bmu_valid_in pulses; on rsp_ready=1 the pending req1 is granted in the same cycle.
- Error pass-through: a=32'h7FFFFFFF, b=1, op=add → rsp_data=32'h80000000, rsp_error=1; with BMU_ARB_ERR_CNT_EN, err_cnt becomes 1 after the handshake.
- Flush in WAIT → no rsp_valid follows; busy=0 next cycle; the next request completes normally.
- Reset asserted in RESP → rsp_valid=0 immediately; after release the first grant goes to req0.

Source files
------------

// File: rtl/bmu_issue_arbiter.sv
// Round-robin issue arbiter sharing one BMU between NUM_REQ requesters, one op in flight.
// Optional macro BMU_ARB_ERR_CNT_EN adds a saturating err_cnt of error responses.
module bmu_issue_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OP_W    = 23,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_error,
  output logic                    bmu_valid_in,
  output logic [31:0]             bmu_a_in,
  output logic [31:0]             bmu_b_in,
  output logic [OP_W-1:0]         bmu_ap,
  input  logic [31:0]             bmu_result_ff,
  input  logic                    bmu_error,
`ifdef BMU_ARB_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_idx;
  logic            gnt_found, can_grant, grant;

  // A new op may issue from IDLE, or from RESP in the cycle the response drains.
  assign can_grant = rst_l && !flush &&
                     ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign grant     = can_grant && gnt_found;
  assign busy      = (state != IDLE);

  // Two passes give the first valid index above rr_ptr, wrapping to the lowest.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) > rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (ID_W'(i) <= rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = grant ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    req_ready    = '0;
    bmu_valid_in = grant;
    bmu_a_in     = '0;
    bmu_b_in     = '0;
    bmu_ap       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (gnt_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        bmu_a_in     = req_a[32*i +: 32];
        bmu_b_in     = req_b[32*i +: 32];
        bmu_ap       = req_op[OP_W*i +: OP_W];
      end
    end
  end

  // Issue stage: remember the owner; capture stage: BMU result lands one cycle later.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr <= gnt_idx;
        id_q   <= gnt_idx;
      end
      if (flush) begin
        rsp_valid <= 1'b0;
      end else if (state == WAIT) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= bmu_result_ff;
        rsp_error <= bmu_error;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef BMU_ARB_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      err_cnt <= '0;
    else if (rsp_valid && rsp_ready && rsp_error && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bmu_issue_arbiter.sv
// Directed bench for bmu_issue_arbiter with a one-register BMU model (add / xor).
module tb_bmu_issue_arbiter;
  localparam int NUM_REQ = 2;
  localparam int OP_W    = 23;
  localparam int ID_W    = 3;
  localparam logic [OP_W-1:0] OP_ADD = 23'd1;
  localparam logic [OP_W-1:0] OP_XOR = 23'd2;

  logic                    clk = 1'b0;
  logic                    rst_l;
  logic                    flush;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a, req_b;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic                    rsp_valid, rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [31:0]             rsp_data;
  logic                    rsp_error;
  logic                    bmu_valid_in;
  logic [31:0]             bmu_a_in, bmu_b_in;
  logic [OP_W-1:0]         bmu_ap;
  logic [31:0]             bmu_result_ff = '0;
  logic                    bmu_error = 1'b0;
  logic                    busy;
`ifdef BMU_ARB_ERR_CNT_EN
  logic [15:0]             err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bmu_issue_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
    .bmu_ap(bmu_ap), .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
`ifdef BMU_ARB_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  // BMU stand-in: result registered on valid_in, error = signed add overflow.
  always_ff @(posedge clk) begin
    if (bmu_valid_in) begin
      if (bmu_ap == OP_ADD) begin
        bmu_result_ff <= bmu_a_in + bmu_b_in;
        bmu_error     <= (bmu_a_in[31] == bmu_b_in[31]) &&
                         (((bmu_a_in + bmu_b_in) >> 31) != {31'd0, bmu_a_in[31]});
      end else begin
        bmu_result_ff <= bmu_a_in ^ bmu_b_in;
        bmu_error     <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [OP_W-1:0] op);
    req_a[32*i +: 32]      = a;
    req_b[32*i +: 32]      = b;
    req_op[OP_W*i +: OP_W] = op;
    req_valid[i]           = 1'b1;
  endtask

  initial begin
    rst_l = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_bmu_valid", 32'(bmu_valid_in), 0);
    chk("rst_rsp_data", rsp_data, 0);
    cyc(); cyc();
    rst_l = 1'b1;

    // single request
    set_req(0, 32'd5, 32'd7, OP_ADD);
    #1;
    chk("single_ready", 32'(req_ready), 1);
    chk("single_bmu_valid", 32'(bmu_valid_in), 1);
    chk("single_bmu_a", bmu_a_in, 5);
    chk("single_bmu_b", bmu_b_in, 7);
    chk("single_bmu_op", 32'(bmu_ap), 1);
    cyc();
    req_valid = '0;
    #1;
    chk("single_wait_bmu_valid", 32'(bmu_valid_in), 0);
    chk("single_wait_bmu_a", bmu_a_in, 0);
    chk("single_wait_busy", 32'(busy), 1);
    chk("single_wait_rsp_valid", 32'(rsp_valid), 0);
    cyc();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 0);
    chk("single_rsp_data", rsp_data, 12);
    chk("single_rsp_err", 32'(rsp_error), 0);
    rsp_ready = 1'b1;
    cyc();
    chk("single_done_valid", 32'(rsp_valid), 0);
    chk("single_done_busy", 32'(busy), 0);

    // contention right after reset: 0,1,0,1
    rst_l = 1'b0; cyc(); rst_l = 1'b1;
    set_req(0, 32'd10, 32'd1, OP_ADD);
    set_req(1, 32'd20, 32'd2, OP_ADD);
    #1;
    for (int n = 0; n < 4; n++) begin
      chk("cont_ready", 32'(req_ready), 32'(1 << (n % 2)));
      if (n > 0) begin
        chk("cont_rsp_valid", 32'(rsp_valid), 1);
        chk("cont_rsp_id", 32'(rsp_id), 32'((n - 1) % 2));
        chk("cont_rsp_data", rsp_data, ((n - 1) % 2 == 0) ? 32'd11 : 32'd22);
      end
      cyc();
      chk("cont_wait_ready", 32'(req_ready), 0);
      chk("cont_wait_rsp_valid", 32'(rsp_valid), 0);
      cyc();
    end
    req_valid = '0;
    #1;
    chk("cont_last_id", 32'(rsp_id), 1);
    chk("cont_last_data", rsp_data, 22);
    cyc();

    // backpressure: rr_ptr=1, so req0 wins first
    rsp_ready = 1'b0;
    set_req(0, 32'd3, 32'd4, OP_ADD);
    #1;
    chk("bp_ready0", 32'(req_ready), 1);
    cyc();
    req_valid = '0;
    set_req(1, 32'd100, 32'd50, OP_ADD);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_data", rsp_data, 7);
      chk("bp_hold_id", 32'(rsp_id), 0);
      chk("bp_no_issue", 32'(bmu_valid_in), 0);
      chk("bp_no_ready", 32'(req_ready), 0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_b2b_ready", 32'(req_ready), 2);
    chk("bp_b2b_bmu_valid", 32'(bmu_valid_in), 1);
    chk("bp_b2b_bmu_a", bmu_a_in, 100);
    cyc();
    req_valid = '0;
    chk("bp_b2b_rsp_drop", 32'(rsp_valid), 0);
    cyc();
    chk("bp_b2b_rsp_id", 32'(rsp_id), 1);
    chk("bp_b2b_rsp_data", rsp_data, 150);
    cyc();

    // error pass-through: rr_ptr=1, req0 wins
    set_req(0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    cyc();
    req_valid = '0;
    cyc();
    chk("err_rsp_valid", 32'(rsp_valid), 1);
    chk("err_rsp_data", rsp_data, 32'h8000_0000);
    chk("err_rsp_err", 32'(rsp_error), 1);
`ifdef BMU_ARB_ERR_CNT_EN
    chk("err_cnt_before", 32'(err_cnt), 0);
`endif
    cyc();
`ifdef BMU_ARB_ERR_CNT_EN
    chk("err_cnt_after", 32'(err_cnt), 1);
`endif
    chk("err_done_valid", 32'(rsp_valid), 0);

    // flush in WAIT: rr_ptr=0, req1 wins
    set_req(1, 32'd1, 32'd2, OP_XOR);
    #1;
    chk("fl_ready1", 32'(req_ready), 2);
    cyc();
    req_valid = '0;
    set_req(0, 32'd8, 32'd9, OP_ADD);
    flush = 1'b1;
    #1;
    chk("fl_no_grant", 32'(req_ready), 0);
    chk("fl_no_issue", 32'(bmu_valid_in), 0);
    chk("fl_busy_wait", 32'(busy), 1);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_busy_after", 32'(busy), 0);
    chk("fl_rsp_valid", 32'(rsp_valid), 0);
    chk("fl_next_ready", 32'(req_ready), 1);
    chk("fl_next_bmu_a", bmu_a_in, 8);
    cyc();
    req_valid = '0;
    chk("fl_no_stale_rsp", 32'(rsp_valid), 0);
    cyc();
    chk("fl_next_rsp_valid", 32'(rsp_valid), 1);
    chk("fl_next_rsp_id", 32'(rsp_id), 0);
    chk("fl_next_rsp_data", rsp_data, 17);
    cyc();

    // reset while in RESP: rr_ptr=0, req1 wins
    rsp_ready = 1'b0;
    set_req(1, 32'd2, 32'd2, OP_ADD);
    cyc();
    req_valid = '0;
    cyc();
    chk("rr_pre_valid", 32'(rsp_valid), 1);
    chk("rr_pre_id", 32'(rsp_id), 1);
    chk("rr_pre_data", rsp_data, 4);
    rst_l = 1'b0;
    #1;
    chk("rr_valid", 32'(rsp_valid), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_data", rsp_data, 0);
    chk("rr_id", 32'(rsp_id), 0);
    cyc();
    rst_l = 1'b1;
    set_req(0, 32'd6, 32'd6, OP_ADD);
    set_req(1, 32'd9, 32'd9, OP_ADD);
    rsp_ready = 1'b1;
    #1;
    chk("rr_first_grant", 32'(req_ready), 1);
    cyc();
    req_valid = '0;
    cyc();
    chk("rr_rsp_id", 32'(rsp_id), 0);
    chk("rr_rsp_data", rsp_data, 12);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
